// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Purpose  : Shared definitions for the serial link. It holds the receiver
//            state encoding, the frame data width, and the default
//            clocks-per-bit divider that the transmitter also uses.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package serial_pkg;

  localparam int SERIAL_DATA_BITS       = 8;
  // 50 MHz system clock at 115200 baud.
  localparam int SERIAL_CLK_DIV_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_if
// Purpose  : Byte delivery bundle from the serial receiver to the command
//            logic. A valid/ready handshake carries the data, and two status
//            pulses travel alongside it.
// Signals  : data[7:0]  received byte, stable while valid
//            valid      data holds an unconsumed byte
//            ready      consumer accepts data when valid && ready
//            frame_err  one-cycle framing/parity error pulse
//            overrun    one-cycle pulse, completed byte dropped
// Modports : master (receiver side), slave (consumer side)
// Revision : 1.0  initial release
// ============================================================================
interface serial_rx_if;
  import serial_pkg::*;

  logic [SERIAL_DATA_BITS-1:0] data;
  logic                        valid;
  logic                        ready;
  logic                        frame_err;
  logic                        overrun;

  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, overrun, output ready);

endinterface
`default_nettype wire

// File: rtl/serial_sync2.sv
`default_nettype none
// ============================================================================
// Module   : serial_sync2
// Purpose  : Two-flop synchronizer for a single asynchronous input.
// Ports    : clk  system clock
//            rst  synchronous active-high reset (both flops to RESET_VAL)
//            d    asynchronous input
//            q    synchronized output
// Revision : 1.0  initial release
// ============================================================================
module serial_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Purpose  : Asynchronous serial receiver (8N1, LSB first). It recovers
//            bytes from rxd and hands them to the command logic on a
//            valid/ready handshake. Framing errors and overruns are reported
//            as one-cycle pulses. False starts are ignored.
// Params   : CLK_DIV  clocks per bit (>= 4)
// Macro    : SERIAL_RX_PARITY_EN - when defined, an even-parity bit is expected
//            between bit 7 and the stop bit. A parity mismatch raises
//            frame_err and the byte is dropped.
// Ports    : clk  system clock
//            rst  synchronous active-high reset
//            rxd  asynchronous serial input, idles high
//            bus  serial_rx_if.master (data/valid/ready/frame_err/overrun)
// Revision : 1.0  initial release
// ============================================================================
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_DIV = SERIAL_CLK_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rxd,
  serial_rx_if.master  bus
);

  localparam int              TW       = $clog2(CLK_DIV);
  localparam int              HALF     = CLK_DIV / 2;
  localparam logic [TW-1:0]   T_HALF   = TW'(HALF - 1);
  localparam logic [TW-1:0]   T_FULL   = TW'(CLK_DIV - 1);
  localparam logic [2:0]      LAST_BIT = 3'(SERIAL_DATA_BITS - 1);

  logic rx_s;

  serial_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rx_s)
  );

  rx_state_t                   state, state_n;
  logic [TW-1:0]               tmr;
  logic [2:0]                  idx;
  logic [SERIAL_DATA_BITS-1:0] shreg;
  logic [SERIAL_DATA_BITS-1:0] data_q;
  logic                        valid_q, frame_err_q, overrun_q;

  logic tmr_clr, shift_en, commit, bad_frame, par_ok;
  logic tick_half, tick_full;

  assign tick_half = (tmr == T_HALF);
  assign tick_full = (tmr == T_FULL);

`ifdef SERIAL_RX_PARITY_EN
  logic par_load, par_bit;

  always_ff @(posedge clk) begin
    if (rst)           par_bit <= 1'b0;
    else if (par_load) par_bit <= rx_s;
  end

  // Even parity: data bits and parity bit together hold an even number of ones.
  assign par_ok = ~(^shreg ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tmr_clr   = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    bad_frame = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_load  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          tmr_clr = 1'b1;
          state_n = START;
        end
      end
      START: begin
        // The start bit is re-checked mid-bit so that glitches are rejected.
        if (tick_half) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            tmr_clr = 1'b1;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (tick_full) begin
          shift_en = 1'b1;
          tmr_clr  = 1'b1;
          if (idx == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          par_load = 1'b1;
          tmr_clr  = 1'b1;
          state_n  = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          if (!rx_s) begin
            bad_frame = 1'b1;
            state_n   = BREAK;
          end else if (!par_ok) begin
            bad_frame = 1'b1;
            state_n   = IDLE;
          end else begin
            commit  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so that a held-low line
        // does not look like a stream of start bits.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit timer, bit index and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      tmr <= tmr_clr ? '0 : tmr + 1'b1;
      if (state != DATA) idx <= '0;
      else if (shift_en) idx <= idx + 1'b1;
      if (shift_en) shreg[idx] <= rx_s;
    end
  end

  // Holding register. A byte that arrives while an unconsumed byte is held
  // is dropped, unless the old byte is consumed in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= bad_frame;
      overrun_q   <= commit && valid_q && !bus.ready;
      if (commit && (!valid_q || bus.ready)) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_rx
// Purpose  : Self-checking bench for serial_rx at CLK_DIV=16. Frames are
//            described by byte and error flags. The bench predicts when and
//            what each frame reports from the bit-timing arithmetic, and a
//            cycle-level model of the holding register is compared with the
//            DUT every cycle. Build with SERIAL_RX_PARITY_EN to cover parity.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_rx;
  import serial_pkg::*;

  localparam int C    = 16;
  localparam int HALF = C / 2;
`ifdef SERIAL_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  // Output latency from the cycle in which rxd falls: 2 sync flops, 1 IDLE
  // cycle, half a bit, then one full bit per data/parity bit up to the stop
  // sample. The result is visible one cycle after the stop sample.
  localparam int LAT = 3 + HALF + (9 + PAR_EN) * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  serial_rx_if bus ();

  serial_rx #(.CLK_DIV(C)) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  bit  rand_rdy = 1'b0;

  // Expected frame results keyed by the cycle in which they become visible:
  // 1 = byte delivered, 2 = frame error.
  int        ev_kind[int];
  bit [7:0]  ev_data[int];

  bit [7:0]  m_data;
  bit        m_valid, m_ferr, m_ovr;
  bit        prev_valid;
  int        last_rise = -1;
  int        ovr_cnt = 0, ferr_cnt = 0, valid_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    bit hs;
    cyc++;
    hs     = m_valid && (bus.ready === 1'b1);
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      m_data  = '0;
      m_valid = 1'b0;
      ev_kind.delete();
      ev_data.delete();
    end else if (ev_kind.exists(cyc)) begin
      if (ev_kind[cyc] == 1) begin
        if (!m_valid || hs) begin
          m_data  = ev_data[cyc];
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        m_ferr = 1'b1;
        if (hs) m_valid = 1'b0;
      end
      ev_kind.delete(cyc);
      ev_data.delete(cyc);
    end else if (hs) begin
      m_valid = 1'b0;
    end
    #1;
    if (chk_en) begin
      check("valid", 32'(bus.valid), 32'(m_valid));
      check("data", 32'(bus.data), 32'(m_data));
      check("frame_err", 32'(bus.frame_err), 32'(m_ferr));
      check("overrun", 32'(bus.overrun), 32'(m_ovr));
    end
    if (bus.valid === 1'b1 && !prev_valid) begin
      last_rise = cyc;
      valid_cnt++;
    end
    prev_valid = (bus.valid === 1'b1);
    if (bus.overrun === 1'b1)   ovr_cnt++;
    if (bus.frame_err === 1'b1) ferr_cnt++;
  end

  // Hold one bit value for a full bit time. Inputs change on falling edges.
  task automatic drive_bit(input bit v);
    rxd = v;
    repeat (C) begin
      @(negedge clk);
      if (rand_rdy) bus.ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame and schedules its expected result. Called on a falling
  // edge. The line is left at the stop-bit level.
  task automatic send_frame(input bit [7:0] b, input bit stop_ok, input bit par_good);
    int t0;
    t0 = cyc;
    ev_kind[t0 + LAT] = (stop_ok && par_good) ? 1 : 2;
    ev_data[t0 + LAT] = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit((^b) ^ !par_good);
`endif
    drive_bit(stop_ok);
  endtask

  initial begin
    int t, o, f, v;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    rst = 1'b0;

    // Idle line: nothing may be reported.
    idle(200);
    check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
    check("idle_ferr_cnt", 32'(ferr_cnt), 32'd0);
    check("idle_ovr_cnt", 32'(ovr_cnt), 32'd0);

    // Single byte with the consumer ready: fixed latency, one-cycle valid.
    bus.ready = 1'b1;
    t = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    check("a5_latency", 32'(last_rise - t), 32'd155);

    // Back-to-back frames into a full holding register.
    bus.ready = 1'b0;
    o = ovr_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    idle(20);
    check("b2b_overrun_cnt", 32'(ovr_cnt - o), 32'd1);
    check("b2b_held_data", 32'(bus.data), 32'h3C);
    check("b2b_held_valid", 32'(bus.valid), 32'd1);
    bus.ready = 1'b1;
    repeat (2) @(negedge clk);
    check("b2b_valid_drop", 32'(bus.valid), 32'd0);

    // False start: 4 low cycles are rejected at the mid-start sample.
    f = ferr_cnt; v = valid_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(60);
    check("false_start_ferr", 32'(ferr_cnt - f), 32'd0);
    check("false_start_valid", 32'(valid_cnt - v), 32'd0);

    // Bad stop bit followed by a held-low line, then recovery.
    f = ferr_cnt; v = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    check("break_ferr_cnt", 32'(ferr_cnt - f), 32'd1);
    check("break_valid_cnt", 32'(valid_cnt - v), 32'd0);
    idle(10);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(20);
    check("after_break_data", 32'(bus.data), 32'h12);
    check("after_break_valid_cnt", 32'(valid_cnt - v), 32'd1);

`ifdef SERIAL_RX_PARITY_EN
    f = ferr_cnt; v = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_good_valid", 32'(valid_cnt - v), 32'd1);
    check("par_good_data", 32'(bus.data), 32'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("par_bad_ferr", 32'(ferr_cnt - f), 32'd1);
    check("par_bad_valid", 32'(valid_cnt - v), 32'd1);
`endif

    // Reset in the middle of a frame: the partial byte is lost.
    v = valid_cnt;
    rxd = 1'b0;
    repeat (C * 3) @(negedge clk);
    rxd = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(bus.valid), 32'd0);
    idle(C * 12);
    check("midrst_no_byte", 32'(valid_cnt - v), 32'd0);
    send_frame(8'h9E, 1'b1, 1'b1);
    idle(20);
    check("midrst_recover", 32'(bus.data), 32'h9E);

    // Randomized frames, gaps and consumer backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bit [7:0] b;
      bit       sok, pok;
      b   = 8'($urandom);
      sok = ($urandom_range(0, 6) != 0);
      pok = (PAR_EN == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
      send_frame(b, sok, pok);
      if (!sok)                        idle($urandom_range(2, 30));
      else if ($urandom_range(0, 1)) idle($urandom_range(1, 40));
      else                             rxd = 1'b1;
    end
    rand_rdy = 1'b0;
    bus.ready = 1'b1;
    idle(C * 12);
    check("rand_events_drained", 32'(ev_kind.num()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
